floor_display_driver: RTL and testbench

Parametrised multi-digit seven-segment driver for the elevator floor indicator. Accepts a binary floor number, converts it to BCD sequentially (shift-and-add-3, one bit per cycle) and time-multiplexes the digits onto one shared segment bus with a one-hot digit enable. Adds leading-zero blanking, blinking (door/arrival indication) and overflow indication. It sits between the elevator controller and the panel pins and supersedes the single-digit combinational decoder.

---
 rtl/floor_display_driver.sv | 174 +++++++++++++++++
 tb/tb_floor_display_driver.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/floor_display_driver.sv
`default_nettype none
// =============================================================================
// floor_display_driver : serial binary-to-BCD conversion feeding a multiplexed
//   seven-segment scan with leading-zero blanking, blink and overflow dash.
// Revision: 1.0
// =============================================================================
module floor_display_driver #(
   parameter int DIGITS    = 2,
   parameter int BIN_W     = 7,
   parameter int SCAN_DIV  = 1000,
   parameter int BLINK_DIV = 500000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [BIN_W-1:0]  value,
   input  logic              blank_lz,
   input  logic              blink_en,
   output logic [6:0]        seg,
   output logic [DIGITS-1:0] dig_en,
   output logic              busy,
   output logic              ovf
);

   localparam int c_limit = 10 ** DIGITS;
   localparam int c_dw    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int c_sw    = $clog2(SCAN_DIV);
   localparam int c_bw    = $clog2(BLINK_DIV);
   localparam int c_cw    = $clog2(BIN_W + 1);
   localparam int c_nw    = DIGITS * 4;

   typedef enum logic [0:0] {IDLE = 1'b0, CONV = 1'b1} state_t;

   state_t           r_state, w_state_nxt;
   logic [BIN_W-1:0] r_bin;
   logic [c_nw-1:0]  r_bcd, r_disp, w_bcd_adj;
   logic [c_cw-1:0]  r_iter;
   logic             r_ovf_pend;
   logic             w_accept, w_commit;
   logic [c_sw-1:0]  r_scnt, w_scnt_nxt;
   logic [c_dw-1:0]  r_didx, w_didx_nxt;
   logic [c_bw-1:0]  r_bcnt, w_bcnt_nxt;
   logic             r_phase, w_phase_nxt;
   logic [3:0]       w_code;
   logic             w_lz;
   logic [6:0]       w_seg_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   // The commit cycle (r_iter == BIN_W) may already accept the next load.
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_commit    = 1'b0;
      case (r_state)
         IDLE: begin
            if (load) begin
               w_accept    = 1'b1;
               w_state_nxt = CONV;
            end
         end
         CONV: begin
            if (r_iter == c_cw'(BIN_W)) begin
               w_commit    = 1'b1;
               w_state_nxt = IDLE;
               if (load) begin
                  w_accept    = 1'b1;
                  w_state_nxt = CONV;
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      w_bcd_adj = r_bcd;
      for (int i = 0; i < DIGITS; i++) begin
         if (r_bcd[i*4 +: 4] >= 4'd5) w_bcd_adj[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bin      <= '0;
         r_bcd      <= '0;
         r_iter     <= '0;
         r_ovf_pend <= 1'b0;
         r_disp     <= '1;
         ovf        <= 1'b0;
         busy       <= 1'b0;
      end else begin
         if (w_accept) begin
            r_bin      <= value;
            r_bcd      <= '0;
            r_iter     <= '0;
            r_ovf_pend <= (value >= BIN_W'(c_limit));
         end else if (r_state == CONV && !w_commit) begin
            // Digits above DIGITS are dropped; they only matter when ovf is set.
            r_bcd  <= c_nw'({w_bcd_adj, r_bin[BIN_W-1]});
            r_bin  <= r_bin << 1;
            r_iter <= r_iter + 1'b1;
         end
         if (w_commit) begin
            r_disp <= r_bcd;
            ovf    <= r_ovf_pend;
         end
         busy <= (r_state == CONV) && !w_commit;
      end
   end

   always_comb begin
      w_scnt_nxt  = r_scnt + 1'b1;
      w_didx_nxt  = r_didx;
      w_bcnt_nxt  = r_bcnt + 1'b1;
      w_phase_nxt = r_phase;
      if (r_scnt == c_sw'(SCAN_DIV - 1)) begin
         w_scnt_nxt = '0;
         w_didx_nxt = (r_didx == c_dw'(DIGITS - 1)) ? '0 : r_didx + 1'b1;
      end
      if (r_bcnt == c_bw'(BLINK_DIV - 1)) begin
         w_bcnt_nxt  = '0;
         w_phase_nxt = ~r_phase;
      end
   end

   // Segment pattern is computed for the digit enabled after this edge.
   always_comb begin
      w_code = r_disp[{w_didx_nxt, 2'b00} +: 4];
      w_lz   = blank_lz && (w_didx_nxt != '0);
      for (int i = 0; i < DIGITS; i++) begin
         if (i >= int'(w_didx_nxt) && r_disp[i*4 +: 4] != 4'd0) w_lz = 1'b0;
      end
      case (w_code)
         4'd0:    w_seg_nxt = 7'b1111110;
         4'd1:    w_seg_nxt = 7'b0110000;
         4'd2:    w_seg_nxt = 7'b1101101;
         4'd3:    w_seg_nxt = 7'b1111001;
         4'd4:    w_seg_nxt = 7'b0110011;
         4'd5:    w_seg_nxt = 7'b1011011;
         4'd6:    w_seg_nxt = 7'b1011111;
         4'd7:    w_seg_nxt = 7'b1110000;
         4'd8:    w_seg_nxt = 7'b1111111;
         4'd9:    w_seg_nxt = 7'b1111011;
         default: w_seg_nxt = 7'b0000000;
      endcase
      if (ovf)       w_seg_nxt = 7'b0000001;
      else if (w_lz) w_seg_nxt = 7'b0000000;
      if (blink_en && w_phase_nxt) w_seg_nxt = 7'b0000000;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_scnt  <= '0;
         r_didx  <= '0;
         r_bcnt  <= '0;
         r_phase <= 1'b0;
         seg     <= 7'b0000000;
         dig_en  <= DIGITS'(1);
      end else begin
         r_scnt  <= w_scnt_nxt;
         r_didx  <= w_didx_nxt;
         r_bcnt  <= w_bcnt_nxt;
         r_phase <= w_phase_nxt;
         seg     <= w_seg_nxt;
         dig_en  <= DIGITS'(1) << w_didx_nxt;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_floor_display_driver.sv
`default_nettype none
// =============================================================================
// tb_floor_display_driver : randomized self-checking bench against a
//   cycle-count based model of the floor display.
// Revision: 1.0
// =============================================================================
module tb_floor_display_driver;

   localparam int DIGITS    = 2;
   localparam int BIN_W     = 7;
   localparam int SCAN_DIV  = 4;
   localparam int BLINK_DIV = 16;
   localparam int LIMIT     = 100;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             load = 1'b0;
   logic [BIN_W-1:0] value = '0;
   logic             blank_lz = 1'b0;
   logic             blink_en = 1'b0;
   logic [6:0]       seg;
   logic [DIGITS-1:0] dig_en;
   logic             busy;
   logic             ovf;

   int k;
   int n_checks = 0;
   int n_fail   = 0;
   int m_val    = 0;
   bit m_valid  = 1'b0;

   floor_display_driver #(
      .DIGITS(DIGITS), .BIN_W(BIN_W), .SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV)
   ) dut (
      .clk(clk), .rst_n(rst_n), .load(load), .value(value),
      .blank_lz(blank_lz), .blink_en(blink_en),
      .seg(seg), .dig_en(dig_en), .busy(busy), .ovf(ovf)
   );

   always #5 clk = ~clk;

   // Rising edges since reset release.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) k <= 0;
      else        k <= k + 1;
   end

   function automatic logic [6:0] pat(input int d);
      logic [6:0] tbl [10];
      tbl = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
              7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};
      return tbl[d];
   endfunction

   function automatic int model_idx(input int kk);
      return (kk / SCAN_DIV) % DIGITS;
   endfunction

   function automatic logic [DIGITS-1:0] model_dig(input int kk);
      return DIGITS'(1 << model_idx(kk));
   endfunction

   function automatic logic [6:0] model_seg(input int kk);
      int di, p;
      di = model_idx(kk);
      p  = 10 ** di;
      if (blink_en && ((kk / BLINK_DIV) % 2 == 1)) return 7'b0000000;
      if (!m_valid)                                return 7'b0000000;
      if (m_val >= LIMIT)                          return 7'b0000001;
      if (blank_lz && di > 0 && m_val < p)         return 7'b0000000;
      return pat((m_val / p) % 10);
   endfunction

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic load_val(input int v);
      load  = 1'b1;
      value = BIN_W'(v);
      tick();
      load = 1'b0;
      repeat (BIN_W + 1) tick();
      m_val   = v;
      m_valid = 1'b1;
      tick();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      load  = 1'b0;
      m_valid = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      n_checks++;
      if (seg !== 7'b0 || dig_en !== 2'b01 || busy !== 1'b0 || ovf !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_values: seg=%b dig_en=%b busy=%b ovf=%b, required 0000000 01 0 0",
                  seg, dig_en, busy, ovf);
      end
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick();
         n_checks++;
         if (seg !== 7'b0 || dig_en !== model_dig(k) || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle k=%0d: seg=%b dig_en=%b busy=%b, required 0000000 %b 0",
                     k, seg, dig_en, busy, model_dig(k));
         end
      end
   endtask

   task automatic test_convert_42();
      int nbusy;
      nbusy = 0;
      load  = 1'b1;
      value = 7'd42;
      tick();
      load = 1'b0;
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL busy_start: busy=%b, required 0", busy);
      end
      for (int i = 1; i <= BIN_W + 1; i++) begin
         tick();
         n_checks++;
         if (busy !== (i <= BIN_W)) begin
            n_fail++;
            $display("FAIL busy_timing cycle %0d: busy=%b, required %b", i, busy, i <= BIN_W);
         end
      end
      m_val = 42;
      m_valid = 1'b1;
      tick();
      for (int i = 0; i < 16; i++) begin
         tick();
         n_checks++;
         if (seg !== model_seg(k) || dig_en !== model_dig(k)) begin
            n_fail++;
            $display("FAIL conv42 k=%0d: seg=%b dig_en=%b, required %b %b",
                     k, seg, dig_en, model_seg(k), model_dig(k));
         end
      end
      n_checks++;
      if (ovf !== 1'b0) begin
         n_fail++;
         $display("FAIL conv42_ovf: ovf=%b, required 0", ovf);
      end
   endtask

   task automatic test_blanking();
      int vals [3];
      bit blz  [3];
      vals = '{7, 7, 0};
      blz  = '{1'b1, 1'b0, 1'b1};
      for (int t = 0; t < 3; t++) begin
         blank_lz = blz[t];
         load_val(vals[t]);
         for (int i = 0; i < 8; i++) begin
            tick();
            n_checks++;
            if (seg !== model_seg(k) || dig_en !== model_dig(k)) begin
               n_fail++;
               $display("FAIL blank v=%0d blz=%0d k=%0d: seg=%b dig_en=%b, required %b %b",
                        vals[t], blz[t], k, seg, dig_en, model_seg(k), model_dig(k));
            end
         end
      end
      blank_lz = 1'b0;
   endtask

   task automatic test_overflow();
      int vals [2];
      vals = '{123, 5};
      for (int t = 0; t < 2; t++) begin
         blank_lz = (t == 0);
         load_val(vals[t]);
         n_checks++;
         if (ovf !== (vals[t] >= LIMIT)) begin
            n_fail++;
            $display("FAIL ovf v=%0d: ovf=%b, required %b", vals[t], ovf, vals[t] >= LIMIT);
         end
         for (int i = 0; i < 8; i++) begin
            tick();
            n_checks++;
            if (seg !== model_seg(k)) begin
               n_fail++;
               $display("FAIL ovf_seg v=%0d k=%0d: seg=%b, required %b",
                        vals[t], k, seg, model_seg(k));
            end
         end
      end
      blank_lz = 1'b0;
   endtask

   task automatic test_blink();
      load_val(42);
      blink_en = 1'b1;
      for (int i = 0; i < 64; i++) begin
         tick();
         n_checks++;
         if (seg !== model_seg(k) || dig_en !== model_dig(k)) begin
            n_fail++;
            $display("FAIL blink k=%0d: seg=%b dig_en=%b, required %b %b",
                     k, seg, dig_en, model_seg(k), model_dig(k));
         end
      end
      blink_en = 1'b0;
   endtask

   task automatic test_random();
      int v;
      for (int t = 0; t < 20; t++) begin
         v        = int'($urandom_range(0, 127));
         blank_lz = 1'($urandom);
         blink_en = ($urandom_range(0, 3) == 0);
         load_val(v);
         n_checks++;
         if (ovf !== (v >= LIMIT)) begin
            n_fail++;
            $display("FAIL rand_ovf v=%0d: ovf=%b, required %b", v, ovf, v >= LIMIT);
         end
         for (int i = 0; i < 8; i++) begin
            tick();
            n_checks++;
            if (seg !== model_seg(k) || dig_en !== model_dig(k)) begin
               n_fail++;
               $display("FAIL rand v=%0d blz=%0d ben=%0d k=%0d: seg=%b dig_en=%b, required %b %b",
                        v, blank_lz, blink_en, k, seg, dig_en, model_seg(k), model_dig(k));
            end
         end
      end
      blank_lz = 1'b0;
      blink_en = 1'b0;
   endtask

   task automatic test_back_to_back();
      // Load during busy must be ignored.
      load  = 1'b1;
      value = 7'd42;
      tick();
      load = 1'b0;
      repeat (2) tick();
      load  = 1'b1;
      value = 7'd99;
      tick();
      load = 1'b0;
      repeat (BIN_W - 2) tick();
      m_val = 42;
      m_valid = 1'b1;
      repeat (2) tick();
      for (int i = 0; i < 8; i++) begin
         tick();
         n_checks++;
         if (seg !== model_seg(k) || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore_busy_load k=%0d: seg=%b busy=%b, required %b 0",
                     k, seg, busy, model_seg(k));
         end
      end
      // Load presented on the commit edge is accepted.
      load  = 1'b1;
      value = 7'd42;
      tick();
      load = 1'b0;
      repeat (BIN_W) tick();
      load  = 1'b1;
      value = 7'd13;
      tick();
      load = 1'b0;
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL commit_edge_load_busy: busy=%b, required 0", busy);
      end
      tick();
      n_checks++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL commit_edge_load_accept: busy=%b, required 1", busy);
      end
      repeat (BIN_W) tick();
      m_val = 13;
      repeat (2) tick();
      for (int i = 0; i < 8; i++) begin
         tick();
         n_checks++;
         if (seg !== model_seg(k)) begin
            n_fail++;
            $display("FAIL commit_edge_value k=%0d: seg=%b, required %b", k, seg, model_seg(k));
         end
      end
   endtask

   task automatic test_reset_mid();
      load  = 1'b1;
      value = 7'd42;
      tick();
      load = 1'b0;
      repeat (3) tick();
      rst_n   = 1'b0;
      m_valid = 1'b0;
      #1;
      n_checks++;
      if (seg !== 7'b0 || dig_en !== 2'b01 || busy !== 1'b0 || ovf !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid: seg=%b dig_en=%b busy=%b ovf=%b, required 0000000 01 0 0",
                  seg, dig_en, busy, ovf);
      end
      do_reset();
      for (int i = 0; i < 10; i++) begin
         tick();
         n_checks++;
         if (seg !== 7'b0 || dig_en !== model_dig(k) || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_idle k=%0d: seg=%b dig_en=%b busy=%b, required 0000000 %b 0",
                     k, seg, dig_en, busy, model_dig(k));
         end
      end
      load_val(3);
      for (int i = 0; i < 8; i++) begin
         tick();
         n_checks++;
         if (seg !== model_seg(k) || dig_en !== model_dig(k)) begin
            n_fail++;
            $display("FAIL reset_mid_load3 k=%0d: seg=%b dig_en=%b, required %b %b",
                     k, seg, dig_en, model_seg(k), model_dig(k));
         end
      end
   endtask

   initial begin
      test_reset();
      test_convert_42();
      test_blanking();
      test_overflow();
      test_blink();
      test_random();
      test_back_to_back();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
